// File: rtl/sn76489_wr_fifo.sv
// Write buffer between the CPU PSG port and sn76489_top: an 8-entry byte FIFO
// drained through the chip's ce_n/we_n/ready handshake with an acknowledge timeout.
module sn76489_wr_fifo #(
    parameter int DEPTH_LOG2_G  = 3,
    parameter int ACK_TIMEOUT_G = 256
) (
    input  logic                  clock_i,
    input  logic                  res_n_i,
    input  logic                  cpu_we_i,
    input  logic [0:7]            cpu_d_i,
    output logic                  cpu_wait_o,
    output logic [DEPTH_LOG2_G:0] count_o,
    output logic                  overflow_o,
    output logic                  timeout_o,
    output logic                  psg_ce_n_o,
    output logic                  psg_we_n_o,
    output logic [0:7]            psg_d_o,
    input  logic                  psg_ready_i
);
    localparam int DEPTH_C   = 2**DEPTH_LOG2_G;
    localparam int TIMER_W_C = (ACK_TIMEOUT_G > 1) ? $clog2(ACK_TIMEOUT_G) : 1;
    localparam logic [DEPTH_LOG2_G:0]   CNT_ZERO_C = {(DEPTH_LOG2_G+1){1'b0}};
    localparam logic [DEPTH_LOG2_G:0]   CNT_ONE_C  = {{DEPTH_LOG2_G{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2_G:0]   CNT_FULL_C = (DEPTH_LOG2_G+1)'(DEPTH_C);
    localparam logic [DEPTH_LOG2_G-1:0] PTR_ONE_C  = (DEPTH_LOG2_G)'(1);
    localparam logic [TIMER_W_C-1:0]    TMR_ZERO_C = {TIMER_W_C{1'b0}};
    localparam logic [TIMER_W_C-1:0]    TMR_ONE_C  = (TIMER_W_C)'(1);
    localparam logic [TIMER_W_C-1:0]    TMR_LAST_C = (TIMER_W_C)'(ACK_TIMEOUT_G - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    logic [0:7]              mem_r [DEPTH_C];
    logic [DEPTH_LOG2_G-1:0] wr_ptr_r;
    logic [DEPTH_LOG2_G-1:0] rd_ptr_r;
    logic [DEPTH_LOG2_G:0]   count_r;
    logic [DEPTH_LOG2_G:0]   count_nxt_s;
    logic                    wait_r;
    logic                    overflow_r;
    logic                    full_s;
    logic                    push_s;
    logic                    pop_s;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [TIMER_W_C-1:0]    timer_r;
    logic [TIMER_W_C-1:0]    timer_nxt_s;
    logic                    ce_n_r;
    logic                    ce_n_nxt_s;
    logic [0:7]              d_r;
    logic [0:7]              d_nxt_s;
    logic                    timeout_r;
    logic                    timeout_nxt_s;

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign full_s = (count_r == CNT_FULL_C);
    assign push_s = cpu_we_i && (!full_s || pop_s);

    // Occupancy update; simultaneous push and pop cancel out.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE_C;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Byte storage, written at the write pointer.
    always_ff @(posedge clock_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= cpu_d_i;
        end
    end

    // FIFO pointers, occupancy and CPU-side status flags.
    always_ff @(posedge clock_i or negedge res_n_i) begin
        if (!res_n_i) begin
            wr_ptr_r   <= {DEPTH_LOG2_G{1'b0}};
            rd_ptr_r   <= {DEPTH_LOG2_G{1'b0}};
            count_r    <= CNT_ZERO_C;
            wait_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r    <= count_nxt_s;
            wait_r     <= (count_nxt_s == CNT_FULL_C);
            overflow_r <= cpu_we_i && !push_s;
        end
    end

    // PSG access sequencer: next state, next registered outputs and pop request.
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        ce_n_nxt_s    = ce_n_r;
        d_nxt_s       = d_r;
        timeout_nxt_s = 1'b0;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_ZERO_C) begin
                    d_nxt_s     = mem_r[rd_ptr_r];
                    ce_n_nxt_s  = 1'b0;
                    timer_nxt_s = TMR_ZERO_C;
                    state_nxt_s = ST_STROBE;
                end else begin
                    ce_n_nxt_s  = 1'b1;
                end
            end
            ST_STROBE: begin
                if (!psg_ready_i) begin
                    state_nxt_s   = ST_BUSY;
                end else if (timer_r == TMR_LAST_C) begin
                    pop_s         = 1'b1;
                    ce_n_nxt_s    = 1'b1;
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = ST_RECOVER;
                end else begin
                    timer_nxt_s   = timer_r + TMR_ONE_C;
                end
            end
            ST_BUSY: begin
                if (psg_ready_i) begin
                    pop_s       = 1'b1;
                    ce_n_nxt_s  = 1'b1;
                    state_nxt_s = ST_RECOVER;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_RECOVER: begin
                ce_n_nxt_s  = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                ce_n_nxt_s  = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and PSG-side output registers.
    always_ff @(posedge clock_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state_r   <= ST_IDLE;
            timer_r   <= TMR_ZERO_C;
            ce_n_r    <= 1'b1;
            d_r       <= 8'h00;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            ce_n_r    <= ce_n_nxt_s;
            d_r       <= d_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    assign cpu_wait_o = wait_r;
    assign count_o    = count_r;
    assign overflow_o = overflow_r;
    assign timeout_o  = timeout_r;
    assign psg_ce_n_o = ce_n_r;
    assign psg_we_n_o = ce_n_r;
    assign psg_d_o    = d_r;

endmodule

// File: tb/tb_sn76489_wr_fifo.sv
// Directed bench for sn76489_wr_fifo: a behavioural PSG answers each strobe
// with a programmable ready drop, and every captured byte is checked against the write order.
`timescale 1ns/1ps
module tb_sn76489_wr_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_we = 1'b0;
    logic [0:7] cpu_d = 8'h00;
    logic       cpu_wait;
    logic [3:0] count;
    logic       overflow;
    logic       timeout;
    logic       psg_ce_n;
    logic       psg_we_n;
    logic [0:7] psg_d;
    logic       psg_ready;

    int checks = 0;
    int failures = 0;

    // PSG model controls and observations
    int         drop_at = 2;
    int         busy_len = 32;
    bit         stopped = 1'b0;
    bit         rand_mode = 1'b0;
    bit         active = 1'b0;
    bit         released = 1'b0;
    int         cnt = 0;
    logic [7:0] cur = 8'h00;
    logic [7:0] acc_q[$];
    logic [7:0] exp_q[$];
    int         ovf_cnt = 0;
    int         to_cnt = 0;
    int         d_unstable = 0;
    int         we_mismatch = 0;
    int         max_count = 0;
    int         last_len = 0;

    sn76489_wr_fifo #(.DEPTH_LOG2_G(3), .ACK_TIMEOUT_G(256)) dut (
        .clock_i    (clk),
        .res_n_i    (rst_n),
        .cpu_we_i   (cpu_we),
        .cpu_d_i    (cpu_d),
        .cpu_wait_o (cpu_wait),
        .count_o    (count),
        .overflow_o (overflow),
        .timeout_o  (timeout),
        .psg_ce_n_o (psg_ce_n),
        .psg_we_n_o (psg_we_n),
        .psg_d_o    (psg_d),
        .psg_ready_i(psg_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_stats();
        acc_q.delete();
        exp_q.delete();
        ovf_cnt = 0; to_cnt = 0; d_unstable = 0; we_mismatch = 0;
        max_count = 0; last_len = 0; released = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        cpu_we = 1'b1;
        cpu_d  = b;
        @(posedge clk); #2;
        cpu_we = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #2;
            if (count == 4'd0 && psg_ce_n == 1'b1) done = 1'b1;
        end
        if (!done) check_eq("drain_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    // Behavioural PSG plus output monitor, sampled on the falling edge
    initial begin
        psg_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
                psg_ready = 1'b1;
                released = 1'b0;
            end else begin
                if (overflow) ovf_cnt++;
                if (timeout) to_cnt++;
                if (int'(count) > max_count) max_count = int'(count);
                if (psg_we_n !== psg_ce_n) we_mismatch++;
                if (!psg_ce_n) begin
                    if (!active) begin
                        active = 1'b1;
                        released = 1'b0;
                        cur = psg_d;
                        acc_q.push_back(psg_d);
                        cnt = 0;
                        if (rand_mode) busy_len = int'($urandom_range(40, 1));
                    end else begin
                        cnt++;
                        if (psg_d !== cur) d_unstable++;
                    end
                    if (!stopped) begin
                        if (cnt == drop_at) psg_ready = 1'b0;
                        else if (cnt == drop_at + busy_len) begin
                            psg_ready = 1'b1;
                            released = 1'b1;
                        end
                    end
                end else begin
                    if (active) last_len = cnt + 1;
                    active = 1'b0;
                    psg_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         found;
        int         snap;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        check_eq("rst_count", count, 32'd0);
        check_eq("rst_ce_n", psg_ce_n, 32'd1);
        check_eq("rst_we_n", psg_we_n, 32'd1);
        check_eq("rst_d", psg_d, 32'h00);
        check_eq("rst_wait", cpu_wait, 32'd0);
        check_eq("rst_ovf", overflow, 32'd0);
        check_eq("rst_timeout", timeout, 32'd0);

        // single write, ready drops 2 cycles into the strobe and stays low 32 cycles
        drop_at = 2; busy_len = 32; clear_stats();
        write_byte(8'h9F);
        check_eq("lat_count", count, 32'd1);
        check_eq("lat_ce_t1", psg_ce_n, 32'd1);
        @(posedge clk); #2;
        check_eq("lat_ce_t2", psg_ce_n, 32'd0);
        check_eq("lat_d", psg_d, 32'h9F);
        wait_drain(400);
        check_eq("single_accesses", acc_q.size(), 32'd1);
        check_eq("single_byte", acc_q[0], 32'h9F);
        check_eq("single_count", count, 32'd0);
        check_eq("single_d_stable", d_unstable, 32'd0);

        // burst of eight fills the FIFO, then overflow and push-on-pop
        drop_at = 2; busy_len = 20; clear_stats();
        for (int i = 0; i < 8; i++) begin
            cpu_we = 1'b1;
            cpu_d  = 8'(8'h80 + i);
            @(posedge clk); #2;
        end
        cpu_we = 1'b0;
        check_eq("burst_count", count, 32'd8);
        check_eq("burst_wait", cpu_wait, 32'd1);
        check_eq("burst_no_ovf", ovf_cnt, 32'd0);
        write_byte(8'hAA);
        check_eq("ovf_pulse", overflow, 32'd1);
        check_eq("ovf_count", count, 32'd8);
        @(posedge clk); #2;
        check_eq("ovf_clear", overflow, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk); #1;
            if (released) found = 1'b1;
        end
        check_eq("pop_edge_found", found, 32'd1);
        cpu_we = 1'b1;
        cpu_d  = 8'h88;
        @(posedge clk); #2;
        cpu_we = 1'b0;
        check_eq("pushpop_count", count, 32'd8);
        check_eq("pushpop_no_ovf", overflow, 32'd0);
        wait_drain(2000);
        check_eq("burst_accesses", acc_q.size(), 32'd9);
        for (int i = 0; i < 9; i++) check_eq("burst_seq", acc_q[i], 32'h80 + 32'(i));
        check_eq("burst_ovf_total", ovf_cnt, 32'd1);
        check_eq("burst_d_stable", d_unstable, 32'd0);
        check_eq("burst_we_eq_ce", we_mismatch, 32'd0);

        // PSG never acknowledges: strobe held 256 cycles, then abandoned
        stopped = 1'b1; clear_stats();
        write_byte(8'hE4);
        wait_drain(600);
        check_eq("to_strobe_len", last_len, 32'd256);
        check_eq("to_pulses", to_cnt, 32'd1);
        check_eq("to_count", count, 32'd0);
        check_eq("to_ce_n", psg_ce_n, 32'd1);
        check_eq("to_byte", acc_q[0], 32'hE4);
        stopped = 1'b0;

        // eleven writes with pointer wrap and random busy lengths
        rand_mode = 1'b1; drop_at = 1; clear_stats();
        for (int i = 0; i < 11; i++) begin
            for (int w = 0; w < 500 && cpu_wait; w++) begin
                @(posedge clk); #2;
            end
            check_eq("rand_wait_vs_count", cpu_wait, 32'(count == 4'd8));
            b = 8'($urandom);
            exp_q.push_back(b);
            write_byte(b);
        end
        wait_drain(3000);
        check_eq("rand_accesses", acc_q.size(), 32'd11);
        for (int i = 0; i < 11; i++) check_eq("rand_seq", acc_q[i], exp_q[i]);
        check_eq("rand_max_count_ok", 32'(max_count <= 8), 32'd1);
        check_eq("rand_no_ovf", ovf_cnt, 32'd0);
        check_eq("rand_no_timeout", to_cnt, 32'd0);
        rand_mode = 1'b0;

        // reset asserted while the PSG holds ready low
        drop_at = 1; busy_len = 50; clear_stats();
        write_byte(8'h55);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #2;
            if (!psg_ready && !psg_ce_n) found = 1'b1;
        end
        check_eq("rst_busy_reached", found, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_ce_n", psg_ce_n, 32'd1);
        check_eq("midrst_we_n", psg_we_n, 32'd1);
        check_eq("midrst_count", count, 32'd0);
        snap = acc_q.size();
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        check_eq("postrst_no_access", acc_q.size(), 32'(snap));
        check_eq("postrst_ce_n", psg_ce_n, 32'd1);
        check_eq("postrst_count", count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
